// File: rtl/proc_control_fsm.sv
// Control sequencer for the simple 9-bit processor: fetches an instruction in T0
// and issues per-step register-select, ALU, bus and handshake strobes over T1..T3.
module proc_control_fsm #(
    parameter int unsigned DIN_W = 9
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             run_i,
    input  logic [DIN_W-1:0] din_i,
    output logic [7:0]       rin_o,
    output logic [7:0]       rout_o,
    output logic             ain_o,
    output logic             gin_o,
    output logic             gout_o,
    output logic             dinout_o,
    output logic             addsub_o,
    output logic             done_o,
    output logic [1:0]       tstep_o
);

    localparam int unsigned IR_W  = 9;
    localparam int unsigned SEL_W = 8;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    tstep_e          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [2:0]      opcode, reg_x, reg_y;

    assign opcode = ir_q[8:6];
    assign reg_x  = ir_q[5:3];
    assign reg_y  = ir_q[2:0];

    // Register index k selects bit (7-k): R0 is the MSB.
    function automatic logic [SEL_W-1:0] sel(input logic [2:0] k);
        return SEL_W'(8'h80 >> k);
    endfunction

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        rin_o    = '0;
        rout_o   = '0;
        ain_o    = 1'b0;
        gin_o    = 1'b0;
        gout_o   = 1'b0;
        dinout_o = 1'b0;
        addsub_o = 1'b0;
        done_o   = 1'b0;

        case (state_q)
            T0: begin
                if (run_i) begin
                    ir_d    = din_i[IR_W-1:0];
                    state_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    3'b000: begin
                        rout_o  = sel(reg_y);
                        rin_o   = sel(reg_x);
                        done_o  = 1'b1;
                        state_d = T0;
                    end
                    3'b001: begin
                        dinout_o = 1'b1;
                        rin_o    = sel(reg_x);
                        done_o   = 1'b1;
                        state_d  = T0;
                    end
                    3'b010, 3'b011: begin
                        rout_o  = sel(reg_x);
                        ain_o   = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        done_o  = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            // T2/T3 are only reachable from add/sub; opcode[0] distinguishes sub.
            T2: begin
                rout_o   = sel(reg_y);
                gin_o    = 1'b1;
                addsub_o = opcode[0];
                state_d  = T3;
            end
            T3: begin
                gout_o  = 1'b1;
                rin_o   = sel(reg_x);
                done_o  = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    assign tstep_o = 2'(state_q);

endmodule
